fifo_reader: RTL and testbench

Read-side engine for the synchronous FIFO. It watches `fifo_empty`, issues `fifo_read` pulses, and absorbs the FIFO's one-cycle read latency. Captured words go to a downstream valid/ready stream through a 2-entry output buffer. It sits between the FIFO's read port and any consumer, giving one word per cycle when the consumer never stalls.

---
 rtl/fifo_reader_pkg.sv | 21 ++
 rtl/fifo_reader_buf.sv | 102 ++++++++++
 rtl/fifo_reader.sv | 82 ++++++++
 tb/tb_fifo_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and constants for the FIFO read-side engine.
// Holds the output-buffer occupancy states, the credit limit that bounds
// buffered plus in-flight words, and the rd_count width helper.
package fifo_reader_pkg;

    // Output buffer occupancy, one state per number of held words.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    // Buffered words plus the word in flight may never exceed this.
    localparam int CREDITS = 2;

    // Width of the delivered-word counter for a given FIFO depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 8;
    endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// fifo_reader_buf: 2-entry skid buffer between the FIFO read data and the
// downstream valid/ready stream. Words leave in arrival order; head is the
// oldest held word. Occupancy is tracked by a three-process FSM.
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic [1:0]       occ,
    output logic             valid
);

    occ_state_t       state_reg;
    occ_state_t       state_next;
    logic [width-1:0] mem_reg [CREDITS];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full buffer is only legal when the head leaves on the
    // same edge; a pop from an empty buffer is ignored.
    assign push_ok = push && ((state_reg != TWO) || pop);
    assign pop_ok  = pop && (state_reg != EMPTY);

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Occupancy next state: capture-only grows, pop-only shrinks, both hold.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (push_ok) begin
                    state_next = ONE;
                end
            end
            ONE: begin
                if (push_ok && !pop_ok) begin
                    state_next = TWO;
                end else if (pop_ok && !push_ok) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop_ok && !push_ok) begin
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Occupancy-derived outputs.
    always_comb begin
        occ   = state_reg;
        valid = (state_reg != EMPTY);
    end

    // Entry storage: the captured word lands in the tail slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CREDITS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Ring pointers advance independently on write and read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    assign head = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: read-side engine for the synchronous FIFO. Issues fifo_read
// pops under a credit rule, absorbs the one-cycle read latency and hands
// words to a valid/ready consumer through a 2-entry buffer.
// Optional feature macro: FIFO_READER_CNT_EN enables the rd_count counter of
// delivered words; when undefined rd_count is tied to zero.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int width = 16,
    parameter int depth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic                      fifo_empty,
    input  logic [width-1:0]          fifo_data_out,
    output logic                      fifo_read,
    output logic [width-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [cnt_w(depth)-1:0]   rd_count
);

    localparam int CW = cnt_w(depth);

    logic       inflight_reg;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] used;
    logic       credit_ok;

    assign pop = out_valid && out_ready;

    // Words that will still hold a buffer slot after this edge's pop. A pop
    // only happens with occ >= 1, so the subtraction cannot go negative.
    assign used      = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};
    assign credit_ok = (used < 3'(CREDITS));

    // Gated by rst so no pop request escapes while the engine is held in
    // reset; out_ready feeds straight through for back-to-back throughput.
    assign fifo_read = !rst && rd_en && !fifo_empty && credit_ok;

    // Remember the pop so its data is captured when it appears next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= fifo_read;
        end
    end

    fifo_reader_buf #(
        .width (width)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data (fifo_data_out),
        .pop       (pop),
        .head      (out_data),
        .occ       (occ),
        .valid     (out_valid)
    );

`ifdef FIFO_READER_CNT_EN
    logic [CW-1:0] count_reg;

    // Count delivered words; wraps freely and clears only on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (pop) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign rd_count = count_reg;
`else
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader. A small queue models the
// FIFO (registered empty flag, one-cycle read latency). Inputs change and
// outputs are sampled on the falling clock edge.
module tb_fifo_reader;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int CW = $clog2(D) + 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_read;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] rd_count;

    logic [W-1:0]  fifo_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int nreads;
    int nvalid;
    int bad;

    fifo_reader #(
        .width (W),
        .depth (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_en         (rd_en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read     (fifo_read),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rd_count      (rd_count)
    );

    always #5 clk = ~clk;

    // FIFO model: pop on fifo_read, data valid next cycle, empty registered.
    always @(posedge clk) begin
        if (fifo_read && fifo_q.size() > 0) begin
            fifo_data_out <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preload(input logic [W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(first + W'(i));
        end
    endtask

    // Collect n words from the stream starting at the current sample point.
    task automatic drain(input string tag, input logic [W-1:0] first, input int n);
        logic [W-1:0] exp_word;
        int got;
        exp_word = first;
        got = 0;
        for (int c = 0; c < 200; c++) begin
            if (out_valid && out_ready) begin
                check(tag, 32'(out_data), 32'(exp_word));
                $display("%s word %0d data %h", tag, got, out_data);
                exp_word = exp_word + W'(1);
                got++;
                if (got == n) break;
            end
            @(negedge clk);
        end
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 3 cycles with a non-empty FIFO: no reads, nothing valid.
        rst       = 1'b1;
        rd_en     = 1'b1;
        out_ready = 1'b1;
        preload(16'h0001, 16);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_fifo_read", 32'(fifo_read), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            $display("reset cycle %0d fifo_read %b out_valid %b", i, fifo_read, out_valid);
        end
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        rst = 1'b0;
        #1;
        check("first_read", 32'(fifo_read), 32'd1);

        // Full-rate streaming: valid two cycles after the first read.
        @(negedge clk);
        check("latency_gap", 32'(out_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(i + 1));
            $display("stream word %0d data %h", i, out_data);
        end
        @(negedge clk);
        check("stream_end_valid", 32'(out_valid), 32'd0);
`ifdef FIFO_READER_CNT_EN
        check("stream_rd_count", 32'(rd_count), 32'd16);
`else
        check("stream_rd_count", 32'(rd_count), 32'd0);
`endif

        // Consumer stalled 10+ cycles: two reads, head held at 0x0001.
        out_ready = 1'b0;
        preload(16'h0001, 16);
        nreads = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_read) nreads++;
            if (i >= 3) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'h0001);
            end
        end
        check("stall_reads", 32'(nreads), 32'd2);
        $display("stall reads %0d head %h", nreads, out_data);
        out_ready = 1'b1;
        #1;
        check("stall_resume_read", 32'(fifo_read), 32'd1);
        drain("stall_drain", 16'h0001, 16);

        // Single word then empty: one read, one valid beat of 0xBEEF.
        @(negedge clk);
        preload(16'hBEEF, 1);
        nreads = 0;
        nvalid = 0;
        bad    = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_read) nreads++;
            if (fifo_read && fifo_empty) bad = 1;
            if (out_valid) begin
                nvalid++;
                check("single_data", 32'(out_data), 32'h0000BEEF);
            end
        end
        check("single_reads", 32'(nreads), 32'd1);
        check("single_valid", 32'(nvalid), 32'd1);
        check("single_no_read_empty", 32'(bad), 32'd0);
        $display("single word reads %0d valid beats %0d", nreads, nvalid);

        // rd_en drop after a read: in-flight word still delivered, no new reads.
        @(negedge clk);
        preload(16'h0101, 4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_read) break;
        end
        check("rden_first_read", 32'(fifo_read), 32'd1);
        @(negedge clk);
        rd_en = 1'b0;
        #1;
        nreads = 0;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            if (fifo_read) nreads++;
            if (out_valid) begin
                nvalid++;
                check("rden_inflight_data", 32'(out_data), 32'h0101);
            end
            @(negedge clk);
        end
        check("rden_no_reads", 32'(nreads), 32'd0);
        check("rden_inflight_valid", 32'(nvalid), 32'd1);
        $display("rd_en low reads %0d delivered %0d", nreads, nvalid);
        rd_en = 1'b1;
        drain("rden_resume", 16'h0102, 3);

        // Reset with the buffer committed full (one held, one in flight).
        @(negedge clk);
        out_ready = 1'b0;
        preload(16'h0201, 6);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_fifo_read", 32'(fifo_read), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_rd_count", 32'(rd_count), 32'd0);
        $display("mid-op reset out_valid %b out_data %h", out_valid, out_data);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drain("post_rst", 16'h0203, 4);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
